// File: rtl/ycr_dmem_wb_bridge.sv
// ycr_dmem_wb_bridge
// Turns one DMEM router port (req/ack/resp) into a single-outstanding
// Wishbone B4 classic master cycle. Byte lanes and write-data placement are
// derived from the request width and the low address bits. Misaligned or
// illegal-width requests are answered with an error without touching the
// bus. A bus cycle that never completes is closed by a timeout.
module ycr_dmem_wb_bridge #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TMO_CYC = 255
) (
    input  logic          clk,
    input  logic          rst_n,
    // DMEM router side
    output logic          dmem_req_ack,
    input  logic          dmem_req,
    input  logic          dmem_cmd,
    input  logic [1:0]    dmem_width,
    input  logic [AW-1:0] dmem_addr,
    input  logic [DW-1:0] dmem_wdata,
    output logic [DW-1:0] dmem_rdata,
    output logic [1:0]    dmem_resp,
    // Wishbone master side
    output logic          wbd_stb_o,
    output logic          wbd_cyc_o,
    output logic          wbd_we_o,
    output logic [AW-1:0] wbd_adr_o,
    output logic [3:0]    wbd_sel_o,
    output logic [DW-1:0] wbd_dat_o,
    input  logic [DW-1:0] wbd_dat_i,
    input  logic          wbd_ack_i,
    input  logic          wbd_err_i
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [1:0] RESP_NONE = 2'd0;
    localparam logic [1:0] RESP_OK   = 2'd1;
    localparam logic [1:0] RESP_ER   = 2'd2;

    localparam logic [1:0] WIDTH_BYTE = 2'd0;
    localparam logic [1:0] WIDTH_HALF = 2'd1;
    localparam logic [1:0] WIDTH_WORD = 2'd2;

    // Counter is wide enough to hold TMO_CYC-1; the last counted cycle
    // is the one in which the timeout fires.
    localparam int            CW       = (TMO_CYC < 2) ? 1 : $clog2(TMO_CYC + 1);
    localparam logic [CW-1:0] TMO_LAST = CW'((TMO_CYC > 0) ? (TMO_CYC - 1) : 0);
    localparam bit            TMO_EN   = (TMO_CYC != 0);

    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic          cyc_reg, cyc_next;
    logic          stb_reg, stb_next;
    logic          we_reg, we_next;
    logic [AW-1:0] adr_reg, adr_next;
    logic [3:0]    sel_reg, sel_next;
    logic [DW-1:0] dat_reg, dat_next;
    logic [DW-1:0] rdata_reg, rdata_next;
    logic [1:0]    resp_reg, resp_next;

    logic          req_legal;
    logic [3:0]    sel_calc;
    logic [DW-1:0] dat_shift;
    logic [DW-1:0] dat_masked;
    logic          tmo_hit;

    // Alignment check and byte-lane select for the incoming request.
    always_comb begin
        req_legal = 1'b0;
        sel_calc  = 4'b0000;
        case (dmem_width)
            WIDTH_BYTE: begin
                req_legal = 1'b1;
                sel_calc  = 4'b0001 << dmem_addr[1:0];
            end
            WIDTH_HALF: begin
                req_legal = ~dmem_addr[0];
                sel_calc  = 4'b0011 << dmem_addr[1:0];
            end
            WIDTH_WORD: begin
                req_legal = (dmem_addr[1:0] == 2'b00);
                sel_calc  = 4'b1111;
            end
            default: begin
                req_legal = 1'b0;
                sel_calc  = 4'b0000;
            end
        endcase
    end

    // Right-justified write data moved onto its lanes; lanes not selected
    // are zeroed so stray upper bits of wdata never reach the bus.
    assign dat_shift = dmem_wdata << {dmem_addr[1:0], 3'b000};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign dat_masked[8*gi +: 8] = sel_calc[gi] ? dat_shift[8*gi +: 8] : 8'h00;
        end
    endgenerate

    assign tmo_hit = TMO_EN && (cnt_reg == TMO_LAST);

    // Next-state and bus/response register updates.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        cyc_next   = cyc_reg;
        stb_next   = stb_reg;
        we_next    = we_reg;
        adr_next   = adr_reg;
        sel_next   = sel_reg;
        dat_next   = dat_reg;
        rdata_next = rdata_reg;
        resp_next  = RESP_NONE;

        case (state_reg)
            ST_IDLE: begin
                if (dmem_req) begin
                    if (req_legal) begin
                        state_next = ST_BUSY;
                        cyc_next   = 1'b1;
                        stb_next   = 1'b1;
                        we_next    = dmem_cmd;
                        adr_next   = {dmem_addr[AW-1:2], 2'b00};
                        sel_next   = sel_calc;
                        dat_next   = dat_masked;
                        cnt_next   = '0;
                    end else begin
                        state_next = ST_RESP;
                        resp_next  = RESP_ER;
                    end
                end
            end
            ST_BUSY: begin
                // err has priority over ack; ack has priority over timeout.
                if (wbd_err_i || wbd_ack_i || tmo_hit) begin
                    state_next = ST_RESP;
                    cyc_next   = 1'b0;
                    stb_next   = 1'b0;
                    cnt_next   = '0;
                    if (wbd_err_i) begin
                        resp_next = RESP_ER;
                    end else if (wbd_ack_i) begin
                        resp_next = RESP_OK;
                        if (!we_reg) begin
                            rdata_next = wbd_dat_i;
                        end
                    end else begin
                        resp_next = RESP_ER;
                    end
                end else if (TMO_EN) begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            ST_RESP: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
                cyc_next   = 1'b0;
                stb_next   = 1'b0;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Bus, response and timeout registers; reset drops cyc/stb at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg   <= '0;
            cyc_reg   <= 1'b0;
            stb_reg   <= 1'b0;
            we_reg    <= 1'b0;
            adr_reg   <= '0;
            sel_reg   <= 4'b0000;
            dat_reg   <= '0;
            rdata_reg <= '0;
            resp_reg  <= RESP_NONE;
        end else begin
            cnt_reg   <= cnt_next;
            cyc_reg   <= cyc_next;
            stb_reg   <= stb_next;
            we_reg    <= we_next;
            adr_reg   <= adr_next;
            sel_reg   <= sel_next;
            dat_reg   <= dat_next;
            rdata_reg <= rdata_next;
            resp_reg  <= resp_next;
        end
    end

    assign dmem_req_ack = (state_reg == ST_IDLE);
    assign dmem_rdata   = rdata_reg;
    assign dmem_resp    = resp_reg;
    assign wbd_cyc_o    = cyc_reg;
    assign wbd_stb_o    = stb_reg;
    assign wbd_we_o     = we_reg;
    assign wbd_adr_o    = adr_reg;
    assign wbd_sel_o    = sel_reg;
    assign wbd_dat_o    = dat_reg;

endmodule

// File: tb/tb_ycr_dmem_wb_bridge.sv
// Testbench for ycr_dmem_wb_bridge: table of single transactions plus
// hand-written sequences for timeout, back-to-back, late ack and reset.
module tb_ycr_dmem_wb_bridge;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        dmem_req_ack;
    logic        dmem_req = 1'b0;
    logic        dmem_cmd = 1'b0;
    logic [1:0]  dmem_width = 2'd0;
    logic [31:0] dmem_addr = 32'h0;
    logic [31:0] dmem_wdata = 32'h0;
    logic [31:0] dmem_rdata;
    logic [1:0]  dmem_resp;
    logic        wbd_stb_o;
    logic        wbd_cyc_o;
    logic        wbd_we_o;
    logic [31:0] wbd_adr_o;
    logic [3:0]  wbd_sel_o;
    logic [31:0] wbd_dat_o;
    logic [31:0] wbd_dat_i = 32'h0;
    logic        wbd_ack_i = 1'b0;
    logic        wbd_err_i = 1'b0;

    int checks = 0;
    int errors = 0;

    ycr_dmem_wb_bridge #(.AW(32), .DW(32), .TMO_CYC(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .dmem_req_ack (dmem_req_ack),
        .dmem_req     (dmem_req),
        .dmem_cmd     (dmem_cmd),
        .dmem_width   (dmem_width),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_rdata   (dmem_rdata),
        .dmem_resp    (dmem_resp),
        .wbd_stb_o    (wbd_stb_o),
        .wbd_cyc_o    (wbd_cyc_o),
        .wbd_we_o     (wbd_we_o),
        .wbd_adr_o    (wbd_adr_o),
        .wbd_sel_o    (wbd_sel_o),
        .wbd_dat_o    (wbd_dat_o),
        .wbd_dat_i    (wbd_dat_i),
        .wbd_ack_i    (wbd_ack_i),
        .wbd_err_i    (wbd_err_i)
    );

    always #5 clk = ~clk;

    // slv: 0 = ack, 1 = err, 2 = ack and err together
    typedef struct {
        logic        cmd;
        logic [1:0]  width;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          dly;
        int          slv;
        logic [31:0] sdat;
        logic        issue;
        logic [3:0]  sel;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [1:0]  resp;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        string t;
        t = $sformatf("vec%0d", idx);
        @(negedge clk);
        chk({t, " req_ack_idle"}, 32'(dmem_req_ack), 32'd1);
        dmem_req   = 1'b1;
        dmem_cmd   = v.cmd;
        dmem_width = v.width;
        dmem_addr  = v.addr;
        dmem_wdata = v.wdata;
        @(posedge clk);
        #1;
        dmem_req   = 1'b0;
        dmem_wdata = 32'h0;
        @(negedge clk);
        if (v.issue) begin
            chk({t, " cyc"}, 32'(wbd_cyc_o), 32'd1);
            chk({t, " stb"}, 32'(wbd_stb_o), 32'd1);
            chk({t, " we"}, 32'(wbd_we_o), 32'(v.cmd));
            chk({t, " adr"}, wbd_adr_o, v.adr);
            chk({t, " sel"}, 32'(wbd_sel_o), 32'(v.sel));
            chk({t, " dat_o"}, wbd_dat_o, v.dat);
            chk({t, " req_ack_busy"}, 32'(dmem_req_ack), 32'd0);
            for (int k = 0; k < v.dly; k++) begin
                @(negedge clk);
                chk({t, " wait_cyc"}, 32'(wbd_cyc_o), 32'd1);
                chk({t, " wait_resp"}, 32'(dmem_resp), 32'd0);
            end
            wbd_dat_i = v.sdat;
            wbd_ack_i = (v.slv != 1);
            wbd_err_i = (v.slv != 0);
            @(negedge clk);
            wbd_ack_i = 1'b0;
            wbd_err_i = 1'b0;
            wbd_dat_i = 32'h0BAD_0BAD;
        end
        chk({t, " resp"}, 32'(dmem_resp), 32'(v.resp));
        chk({t, " rdata"}, dmem_rdata, v.rdata);
        chk({t, " cyc_resp"}, 32'(wbd_cyc_o), 32'd0);
        chk({t, " req_ack_resp"}, 32'(dmem_req_ack), 32'd0);
        @(negedge clk);
        chk({t, " resp_one_cycle"}, 32'(dmem_resp), 32'd0);
        chk({t, " req_ack_after"}, 32'(dmem_req_ack), 32'd1);
        $display("txn vec%0d cmd=%0d width=%0d addr=%h resp=%0d rdata=%h",
                 idx, v.cmd, v.width, v.addr, v.resp, v.rdata);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //            cmd width addr          wdata         dly slv sdat          issue sel    adr           dat           resp  rdata
        vecs[0] = '{1'b0, 2'd2, 32'h0001_0008, 32'h0000_0000, 0, 0, 32'hDEAD_BEEF, 1'b1, 4'hF, 32'h0001_0008, 32'h0000_0000, 2'd1, 32'hDEAD_BEEF};
        vecs[1] = '{1'b1, 2'd0, 32'h0001_0003, 32'h0000_00A5, 0, 0, 32'h1111_1111, 1'b1, 4'h8, 32'h0001_0000, 32'hA500_0000, 2'd1, 32'hDEAD_BEEF};
        vecs[2] = '{1'b1, 2'd1, 32'h0002_0000, 32'hFFFF_1234, 1, 0, 32'h2222_2222, 1'b1, 4'h3, 32'h0002_0000, 32'h0000_1234, 2'd1, 32'hDEAD_BEEF};
        vecs[3] = '{1'b1, 2'd1, 32'h0001_0001, 32'h0000_BEEF, 0, 0, 32'h0,         1'b0, 4'h0, 32'h0,         32'h0,         2'd2, 32'hDEAD_BEEF};
        vecs[4] = '{1'b0, 2'd3, 32'h0001_0004, 32'h0000_0000, 0, 0, 32'h0,         1'b0, 4'h0, 32'h0,         32'h0,         2'd2, 32'hDEAD_BEEF};
        vecs[5] = '{1'b0, 2'd0, 32'h0000_0401, 32'h0000_0000, 2, 0, 32'hCAFE_F00D, 1'b1, 4'h2, 32'h0000_0400, 32'h0000_0000, 2'd1, 32'hCAFE_F00D};
        vecs[6] = '{1'b0, 2'd2, 32'h0000_0800, 32'h0000_0000, 0, 2, 32'h3333_3333, 1'b1, 4'hF, 32'h0000_0800, 32'h0000_0000, 2'd2, 32'hCAFE_F00D};
        vecs[7] = '{1'b1, 2'd2, 32'h0000_0802, 32'h1234_5678, 0, 0, 32'h0,         1'b0, 4'h0, 32'h0,         32'h0,         2'd2, 32'hCAFE_F00D};
        vecs[8] = '{1'b0, 2'd1, 32'h0000_0C06, 32'h0000_0000, 0, 0, 32'h55AA_7788, 1'b1, 4'hC, 32'h0000_0C04, 32'h0000_0000, 2'd1, 32'h55AA_7788};
        vecs[9] = '{1'b1, 2'd0, 32'h0000_0C01, 32'hFFFF_FF5A, 1, 1, 32'h4444_4444, 1'b1, 4'h2, 32'h0000_0C00, 32'h0000_5A00, 2'd2, 32'h55AA_7788};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst cyc", 32'(wbd_cyc_o), 32'd0);
        chk("rst stb", 32'(wbd_stb_o), 32'd0);
        chk("rst sel", 32'(wbd_sel_o), 32'd0);
        chk("rst adr", wbd_adr_o, 32'd0);
        chk("rst resp", 32'(dmem_resp), 32'd0);
        chk("rst rdata", dmem_rdata, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle req_ack", 32'(dmem_req_ack), 32'd1);

        for (int i = 0; i < 10; i++) begin
            run_vec(i, vecs[i]);
        end

        // Timeout: TMO_CYC=4, slave silent -> 4 BUSY cycles then RDY_ER
        @(negedge clk);
        dmem_req = 1'b1; dmem_cmd = 1'b0; dmem_width = 2'd2; dmem_addr = 32'h0000_1000;
        @(posedge clk);
        #1 dmem_req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("tmo busy%0d cyc", k), 32'(wbd_cyc_o), 32'd1);
            chk($sformatf("tmo busy%0d resp", k), 32'(dmem_resp), 32'd0);
        end
        @(negedge clk);
        chk("tmo resp", 32'(dmem_resp), 32'd2);
        chk("tmo cyc_drop", 32'(wbd_cyc_o), 32'd0);
        chk("tmo rdata_keep", dmem_rdata, 32'h55AA_7788);
        $display("txn timeout resp=%0d", dmem_resp);
        @(negedge clk);
        chk("tmo resp_clear", 32'(dmem_resp), 32'd0);

        // Back-to-back reads with the next request held through RESP
        dmem_req = 1'b1; dmem_cmd = 1'b0; dmem_width = 2'd2; dmem_addr = 32'h0000_0100;
        @(posedge clk);
        #1 dmem_addr = 32'h0000_0104;
        @(negedge clk);
        chk("b2b first adr", wbd_adr_o, 32'h0000_0100);
        chk("b2b busy req_ack", 32'(dmem_req_ack), 32'd0);
        wbd_ack_i = 1'b1; wbd_dat_i = 32'h0000_0001;
        @(negedge clk);
        wbd_ack_i = 1'b0; wbd_dat_i = 32'h0;
        chk("b2b first resp", 32'(dmem_resp), 32'd1);
        chk("b2b first rdata", dmem_rdata, 32'h0000_0001);
        chk("b2b resp req_ack", 32'(dmem_req_ack), 32'd0);
        $display("txn b2b first rdata=%h", dmem_rdata);
        @(negedge clk);
        chk("b2b idle req_ack", 32'(dmem_req_ack), 32'd1);
        chk("b2b idle cyc", 32'(wbd_cyc_o), 32'd0);
        @(posedge clk);
        #1 dmem_req = 1'b0;
        @(negedge clk);
        chk("b2b second adr", wbd_adr_o, 32'h0000_0104);
        chk("b2b second cyc", 32'(wbd_cyc_o), 32'd1);
        wbd_ack_i = 1'b1; wbd_dat_i = 32'h0000_0002;
        @(negedge clk);
        wbd_ack_i = 1'b0; wbd_dat_i = 32'h0;
        chk("b2b second resp", 32'(dmem_resp), 32'd1);
        chk("b2b second rdata", dmem_rdata, 32'h0000_0002);
        $display("txn b2b second rdata=%h", dmem_rdata);

        // Late ack/err while idle is ignored
        @(negedge clk);
        wbd_ack_i = 1'b1; wbd_err_i = 1'b1; wbd_dat_i = 32'hFFFF_FFFF;
        @(negedge clk);
        wbd_ack_i = 1'b0; wbd_err_i = 1'b0; wbd_dat_i = 32'h0;
        chk("late resp", 32'(dmem_resp), 32'd0);
        chk("late req_ack", 32'(dmem_req_ack), 32'd1);
        chk("late rdata", dmem_rdata, 32'h0000_0002);
        $display("txn late_ack resp=%0d", dmem_resp);

        // Reset while BUSY
        @(negedge clk);
        dmem_req = 1'b1; dmem_cmd = 1'b1; dmem_width = 2'd2; dmem_addr = 32'h0000_0200;
        @(posedge clk);
        #1 dmem_req = 1'b0;
        @(negedge clk);
        chk("rstbusy cyc_before", 32'(wbd_cyc_o), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rstbusy cyc", 32'(wbd_cyc_o), 32'd0);
        chk("rstbusy stb", 32'(wbd_stb_o), 32'd0);
        chk("rstbusy resp", 32'(dmem_resp), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rstbusy idle", 32'(dmem_req_ack), 32'd1);
        chk("rstbusy no_resp", 32'(dmem_resp), 32'd0);
        chk("rstbusy cyc_after", 32'(wbd_cyc_o), 32'd0);
        $display("txn reset_busy cyc=%0d", wbd_cyc_o);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
